// File: rtl/div_iter_pkg.sv
// Shared constants, FSM encoding and two's-complement helpers for the
// iterative 32-bit divider.
package div_iter_pkg;

    localparam int DIV_WIDTH   = 32;
    localparam int DIV_LATENCY = 33;
    localparam int CNT_WIDTH   = 5;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Two's-complement negation
    function automatic logic [DIV_WIDTH-1:0] f_neg(input logic [DIV_WIDTH-1:0] v);
        return (~v) + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude of an operand; negative values only exist in signed mode.
    // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [DIV_WIDTH-1:0] f_mag(input logic [DIV_WIDTH-1:0] v,
                                                   input logic                 is_signed);
        if (is_signed && v[DIV_WIDTH-1]) begin
            return f_neg(v);
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative restoring divider, one quotient bit per clock.
// Operands are taken as magnitudes, signs are re-applied while loading the
// result register, so the total latency is fixed regardless of operand values.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int SIGNED = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_axis_divisor_tvalid,
    output logic                   s_axis_divisor_tready,
    input  logic [DIV_WIDTH-1:0]   s_axis_divisor_tdata,
    input  logic                   s_axis_dividend_tvalid,
    output logic                   s_axis_dividend_tready,
    input  logic [DIV_WIDTH-1:0]   s_axis_dividend_tdata,
    output logic                   m_axis_dout_tvalid,
    output logic [2*DIV_WIDTH-1:0] m_axis_dout_tdata
);

    // Counter value of the final (32nd) shift-subtract step
    localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(DIV_LATENCY - 2);
    localparam logic                 IS_SIGNED = (SIGNED != 0);

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic [CNT_WIDTH-1:0]   r_count;
    logic                   r_ready;
    logic                   r_dout_valid;
    logic [2*DIV_WIDTH-1:0] r_dout_data;

    logic [DIV_WIDTH-1:0]   r_divisor;   // divisor magnitude
    logic [DIV_WIDTH-1:0]   r_quot;      // dividend bits shift out, quotient bits shift in
    logic [DIV_WIDTH-1:0]   r_rem;       // partial remainder
    logic                   r_qsign;
    logic                   r_rsign;
    logic                   r_dzero;

    logic                   w_accept;
    logic                   w_last_iter;
    logic [DIV_WIDTH:0]     w_trial;
    logic [DIV_WIDTH:0]     w_diff;
    logic                   w_ge;
    logic [DIV_WIDTH-1:0]   w_quot_next;
    logic [DIV_WIDTH-1:0]   w_rem_next;
    logic [DIV_WIDTH-1:0]   w_quot_fix;
    logic [DIV_WIDTH-1:0]   w_rem_fix;

    assign w_accept    = (r_state == ST_IDLE) && s_axis_divisor_tvalid && s_axis_dividend_tvalid;
    assign w_last_iter = (r_state == ST_BUSY) && (r_count == LAST_ITER);

    assign s_axis_divisor_tready  = r_ready;
    assign s_axis_dividend_tready = r_ready;
    assign m_axis_dout_tvalid     = r_dout_valid;
    assign m_axis_dout_tdata      = r_dout_data;

    // Next-state decode for IDLE -> BUSY -> DONE -> IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_BUSY;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (w_last_iter) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_BUSY;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // One restoring step: shift the next dividend bit in, subtract if it fits.
    // The trial value can reach 33 bits; when its top bit is set it always
    // exceeds the 32-bit divisor, otherwise the subtractor's sign bit decides.
    always_comb begin
        w_trial = {r_rem, r_quot[DIV_WIDTH-1]};
        w_diff  = w_trial - {1'b0, r_divisor};
        w_ge    = w_trial[DIV_WIDTH] | ~w_diff[DIV_WIDTH];
        if (w_ge) begin
            w_rem_next  = w_diff[DIV_WIDTH-1:0];
            w_quot_next = {r_quot[DIV_WIDTH-2:0], 1'b1};
        end else begin
            w_rem_next  = w_trial[DIV_WIDTH-1:0];
            w_quot_next = {r_quot[DIV_WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction applied on the way into the result register.
    // A zero divisor yields all-ones quotient bits and the dividend magnitude
    // as remainder; forcing the quotient keeps it all-ones in signed mode too.
    always_comb begin
        w_quot_fix = w_quot_next;
        w_rem_fix  = w_rem_next;
        if (r_dzero) begin
            w_quot_fix = {DIV_WIDTH{1'b1}};
        end else if (r_qsign) begin
            w_quot_fix = f_neg(w_quot_next);
        end else begin
            w_quot_fix = w_quot_next;
        end
        if (r_rsign) begin
            w_rem_fix = f_neg(w_rem_next);
        end else begin
            w_rem_fix = w_rem_next;
        end
    end

    // Control registers: state, handshake readiness and result strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_ready      <= 1'b1;
            r_dout_valid <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_ready      <= (w_state_next == ST_IDLE);
            r_dout_valid <= w_last_iter;
        end
    end

    // Operand capture, iteration datapath and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= {CNT_WIDTH{1'b0}};
            r_divisor   <= {DIV_WIDTH{1'b0}};
            r_quot      <= {DIV_WIDTH{1'b0}};
            r_rem       <= {DIV_WIDTH{1'b0}};
            r_qsign     <= 1'b0;
            r_rsign     <= 1'b0;
            r_dzero     <= 1'b0;
            r_dout_data <= {(2*DIV_WIDTH){1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_count   <= {CNT_WIDTH{1'b0}};
                        r_divisor <= f_mag(s_axis_divisor_tdata, IS_SIGNED);
                        r_quot    <= f_mag(s_axis_dividend_tdata, IS_SIGNED);
                        r_rem     <= {DIV_WIDTH{1'b0}};
                        r_qsign   <= IS_SIGNED & (s_axis_dividend_tdata[DIV_WIDTH-1] ^
                                                  s_axis_divisor_tdata[DIV_WIDTH-1]);
                        r_rsign   <= IS_SIGNED & s_axis_dividend_tdata[DIV_WIDTH-1];
                        r_dzero   <= (s_axis_divisor_tdata == {DIV_WIDTH{1'b0}});
                    end
                end
                ST_BUSY: begin
                    r_rem   <= w_rem_next;
                    r_quot  <= w_quot_next;
                    r_count <= r_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    if (w_last_iter) begin
                        r_dout_data <= {w_quot_fix, w_rem_fix};
                    end
                end
                ST_DONE: begin
                    r_count <= {CNT_WIDTH{1'b0}};
                end
                default: begin
                    r_count <= {CNT_WIDTH{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: signed and unsigned instances share the
// same stimulus; results are compared with constant vectors and with an
// arithmetic reference model.
module tb_div_iter;
    import div_iter_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dvs_valid = 1'b0;
    logic        dvd_valid = 1'b0;
    logic [31:0] dvs_data = 32'd0;
    logic [31:0] dvd_data = 32'd0;

    logic        dvs_ready_s, dvd_ready_s, valid_s;
    logic [63:0] data_s;
    logic        dvs_ready_u, dvd_ready_u, valid_u;
    logic [63:0] data_u;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_iter #(.SIGNED(1)) dut_s (
        .clk                    (clk),
        .reset                  (reset),
        .s_axis_divisor_tvalid  (dvs_valid),
        .s_axis_divisor_tready  (dvs_ready_s),
        .s_axis_divisor_tdata   (dvs_data),
        .s_axis_dividend_tvalid (dvd_valid),
        .s_axis_dividend_tready (dvd_ready_s),
        .s_axis_dividend_tdata  (dvd_data),
        .m_axis_dout_tvalid     (valid_s),
        .m_axis_dout_tdata      (data_s)
    );

    div_iter #(.SIGNED(0)) dut_u (
        .clk                    (clk),
        .reset                  (reset),
        .s_axis_divisor_tvalid  (dvs_valid),
        .s_axis_divisor_tready  (dvs_ready_u),
        .s_axis_divisor_tdata   (dvs_data),
        .s_axis_dividend_tvalid (dvd_valid),
        .s_axis_dividend_tready (dvd_ready_u),
        .s_axis_dividend_tdata  (dvd_data),
        .m_axis_dout_tvalid     (valid_u),
        .m_axis_dout_tdata      (data_u)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_s;
        logic [63:0] exp_u;
    } vec_t;

    vec_t vecs[12];

    // Division as the instruction set defines it, in 64-bit arithmetic
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input bit sgn);
        longint sa, sb, q, r;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {q[31:0], r[31:0]};
    endfunction

    task automatic chk(input string tag, input string name,
                       input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s.%s got=%h expected=%h", tag, name, got, exp);
        end
    endtask

    function automatic logic [3:0] readies();
        return {dvs_ready_s, dvd_ready_s, dvs_ready_u, dvd_ready_u};
    endfunction

    // One full transaction with latency, pulse, readiness and data checks
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_s, input logic [63:0] exp_u,
                          input string tag);
        int lat = 0;
        int pulses_s = 0;
        int pulses_u = 0;
        logic [63:0] cap_s = 64'd0;
        logic [63:0] cap_u = 64'd0;
        @(negedge clk);
        chk(tag, "ready_idle", 64'(readies()), 64'hF);
        dvd_data  = a;
        dvs_data  = b;
        dvd_valid = 1'b1;
        dvs_valid = 1'b1;
        @(posedge clk);
        #1;
        dvd_valid = 1'b0;
        dvs_valid = 1'b0;
        dvd_data  = $urandom;
        dvs_data  = $urandom;
        chk(tag, "ready_busy", 64'(readies()), 64'h0);
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (valid_s) begin
                pulses_s++;
                if (pulses_s == 1) begin
                    lat   = n;
                    cap_s = data_s;
                end
            end
            if (valid_u) begin
                pulses_u++;
                cap_u = data_u;
            end
            if (n == DIV_LATENCY - 1) chk(tag, "ready_done", 64'(readies()), 64'h0);
            if (n == DIV_LATENCY)     chk(tag, "ready_back", 64'(readies()), 64'hF);
        end
        chk(tag, "latency",  64'(lat), 64'(DIV_LATENCY - 1));
        chk(tag, "pulses_s", 64'(pulses_s), 64'd1);
        chk(tag, "pulses_u", 64'(pulses_u), 64'd1);
        chk(tag, "data_s",   cap_s, exp_s);
        chk(tag, "data_u",   cap_u, exp_u);
        chk(tag, "hold_s",   data_s, exp_s);
    endtask

    // Count tvalid pulses over a window; any pulse is an error
    task automatic no_pulse(input string tag, input int cycles);
        int seen = 0;
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk);
            #1;
            if (valid_s || valid_u) seen++;
        end
        chk(tag, "no_pulse", 64'(seen), 64'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic [31:0] qa[$];
        logic [31:0] qb[$];
        int          acc_cyc[$];
        int          results;
        int          bad;

        vecs[0]  = '{32'd7,          32'd2,          64'h00000003_00000001, 64'h00000003_00000001};
        vecs[1]  = '{32'hFFFFFFF9,   32'd2,          64'hFFFFFFFD_FFFFFFFF, 64'h7FFFFFFC_00000001};
        vecs[2]  = '{32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, 64'h00000000_80000000};
        vecs[3]  = '{32'hFFFFFFFF,   32'h10,         64'h00000000_FFFFFFFF, 64'h0FFFFFFF_0000000F};
        vecs[4]  = '{32'h1234,       32'd0,          64'hFFFFFFFF_00001234, 64'hFFFFFFFF_00001234};
        vecs[5]  = '{32'd100,        32'd7,          64'h0000000E_00000002, 64'h0000000E_00000002};
        vecs[6]  = '{32'hFFFFFFF9,   32'd0,          64'hFFFFFFFF_FFFFFFF9, 64'hFFFFFFFF_FFFFFFF9};
        vecs[7]  = '{32'd7,          32'hFFFFFFFE,   64'hFFFFFFFD_00000001, 64'h00000000_00000007};
        vecs[8]  = '{32'hFFFFFFF9,   32'hFFFFFFFE,   64'h00000003_FFFFFFFF, 64'h00000000_FFFFFFF9};
        vecs[9]  = '{32'd0,          32'd5,          64'h00000000_00000000, 64'h00000000_00000000};
        vecs[10] = '{32'h80000000,   32'd1,          64'h80000000_00000000, 64'h80000000_00000000};
        vecs[11] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   64'h00000001_00000000, 64'h00000001_00000000};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset", "ready", 64'(readies()), 64'hF);
        chk("reset", "valid", 64'({valid_s, valid_u}), 64'd0);
        chk("reset", "data_s", data_s, 64'd0);
        chk("reset", "data_u", data_u, 64'd0);

        // Constant vectors
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp_s, vecs[i].exp_u, $sformatf("vec%0d", i));
        end

        // Random operands against the reference model
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case (i % 4)
                0:       b = $urandom;
                1:       b = 32'($urandom_range(1, 255));
                2:       b = 32'hFFFFFFFF - 32'($urandom_range(0, 255));
                default: b = (i % 8 == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            endcase
            run_op(a, b, ref_div(a, b, 1'b1), ref_div(a, b, 1'b0), $sformatf("rand%0d", i));
        end

        // Only one channel valid: never accepted
        bad = 0;
        @(negedge clk);
        dvd_valid = 1'b1;
        for (int n = 0; n < 10; n++) begin
            dvd_data = $urandom;
            @(posedge clk);
            #1;
            if (readies() != 4'hF || valid_s || valid_u) bad++;
        end
        dvd_valid = 1'b0;
        dvs_valid = 1'b1;
        for (int n = 0; n < 10; n++) begin
            dvs_data = $urandom;
            @(posedge clk);
            #1;
            if (readies() != 4'hF || valid_s || valid_u) bad++;
        end
        dvs_valid = 1'b0;
        chk("single", "bad_cycles", 64'(bad), 64'd0);
        no_pulse("single", 40);

        // Both valids held high with changing data
        results = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            a = $urandom;
            b = 32'($urandom_range(1, 100000));
            dvd_data  = a;
            dvs_data  = b;
            dvd_valid = 1'b1;
            dvs_valid = 1'b1;
            if (dvs_ready_s) begin
                qa.push_back(a);
                qb.push_back(b);
                acc_cyc.push_back(c);
            end
            @(posedge clk);
            #1;
            if (valid_s) begin
                chk("stream", "expected_result", 64'(qa.size() != 0), 64'd1);
                if (qa.size() != 0) begin
                    a = qa.pop_front();
                    b = qb.pop_front();
                    chk("stream", "data_s", data_s, ref_div(a, b, 1'b1));
                    chk("stream", "data_u", data_u, ref_div(a, b, 1'b0));
                    results++;
                end
            end
        end
        dvd_valid = 1'b0;
        dvs_valid = 1'b0;
        for (int n = 0; n < 40 && qa.size() != 0; n++) begin
            @(posedge clk);
            #1;
            if (valid_s) begin
                a = qa.pop_front();
                b = qb.pop_front();
                chk("stream", "data_s", data_s, ref_div(a, b, 1'b1));
                results++;
            end
        end
        chk("stream", "accepts", 64'(acc_cyc.size()), 64'd3);
        chk("stream", "results", 64'(results), 64'(acc_cyc.size()));
        if (acc_cyc.size() >= 2) begin
            chk("stream", "gap", 64'(acc_cyc[1] - acc_cyc[0]), 64'(DIV_LATENCY + 1));
        end else begin
            chk("stream", "gap_present", 64'(acc_cyc.size()), 64'd2);
        end
        no_pulse("stream_idle", 5);

        // Reset in the middle of BUSY aborts the operation
        @(negedge clk);
        dvd_data  = 32'd1000;
        dvs_data  = 32'd3;
        dvd_valid = 1'b1;
        dvs_valid = 1'b1;
        @(posedge clk);
        #1;
        dvd_valid = 1'b0;
        dvs_valid = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort", "ready", 64'(readies()), 64'hF);
        chk("abort", "valid", 64'({valid_s, valid_u}), 64'd0);
        chk("abort", "data_s", data_s, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        no_pulse("abort", 40);
        run_op(32'd100, 32'd7, 64'h0000000E_00000002, 64'h0000000E_00000002, "after_abort");

        // Reset wins over a simultaneous handshake
        @(negedge clk);
        reset     = 1'b1;
        dvd_data  = 32'd50;
        dvs_data  = 32'd5;
        dvd_valid = 1'b1;
        dvs_valid = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        dvd_valid = 1'b0;
        dvs_valid = 1'b0;
        chk("reset_prio", "ready", 64'(readies()), 64'hF);
        @(posedge clk);
        #1;
        chk("reset_prio", "ready_next", 64'(readies()), 64'hF);
        no_pulse("reset_prio", 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 Parameter SIGNED, default 1, meaning: 1 = two's-complement division (MIPS DIV), 0 = unsigned division (MIPS DIVU).
REQ-002 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1, synchronous active-high reset.
REQ-004 Port s_axis_divisor_tvalid, input, 1, divisor offered.
REQ-005 Port s_axis_divisor_tready, output, 1, divisor can be accepted.
REQ-006 Port s_axis_divisor_tdata, input, 32, divisor.
REQ-007 Port s_axis_dividend_tvalid, input, 1, dividend offered.
REQ-008 Port s_axis_dividend_tready, output, 1, dividend can be accepted.
REQ-009 Port s_axis_dividend_tdata, input, 32, dividend.
REQ-010 Port m_axis_dout_tvalid, output, 1, result-valid pulse; there is no tready.
REQ-011 Port m_axis_dout_tdata, output, 64, result: [63:32] quotient, [31:0] remainder.

Function
REQ-012 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-013 Both tready outputs SHALL be 1 in IDLE and 0 in BUSY and DONE.
REQ-014 Operands SHALL be accepted only on a clk edge in IDLE with both tvalid inputs high; the state then goes to BUSY.
REQ-015 If only one tvalid is high in IDLE, nothing SHALL be accepted and that channel's data SHALL be ignored.
REQ-016 On acceptance, both operands SHALL be captured into internal registers; input data may change afterwards without effect.
REQ-017 On acceptance with SIGNED=1, the block SHALL record operand magnitudes, quotient sign (sign(dividend) XOR sign(divisor)) and remainder sign (sign(dividend)).
REQ-018 BUSY SHALL last exactly 32 cycles, one restoring shift-subtract iteration per cycle, counted by a 5-bit iteration counter.
REQ-019 After the 32nd iteration the state SHALL go to DONE for exactly one cycle with m_axis_dout_tvalid=1, then return to IDLE.
REQ-020 Latency SHALL be fixed: handshake at edge k gives tvalid high in the cycle after edge k+32.
REQ-021 m_axis_dout_tdata SHALL be registered, SHALL hold the last result until the next DONE, and SHALL be valid during the tvalid cycle.
REQ-022 The quotient SHALL truncate toward zero, and the remainder SHALL satisfy dividend = q*divisor + r, with sign of r equal to sign of dividend (signed mode).
REQ-023 Sign correction SHALL be applied when the result register is loaded, not as an extra cycle.
REQ-024 Divisor 0 SHALL produce quotient 0xFFFFFFFF and remainder = dividend in both modes, with no error flag and the same latency.
REQ-025 Signed 0x80000000 / 0xFFFFFFFF SHALL produce quotient 0x80000000 and remainder 0.
REQ-026 tvalid inputs asserted in BUSY or DONE SHALL be ignored; no request is queued.

Reset
REQ-027 Reset SHALL force state IDLE, iteration counter 0, m_axis_dout_tvalid 0, m_axis_dout_tdata 0 and both tready outputs 1 in the cycle after reset.
REQ-028 Reset asserted mid-BUSY or in DONE SHALL abort the operation with no tvalid pulse.
REQ-029 Reset SHALL take priority over a simultaneous handshake.

Structure
REQ-030 A shared package SHALL hold DIV_WIDTH=32, DIV_LATENCY=33 and the FSM state encoding.
REQ-031 The block SHALL be a single module with no sub-module; the iteration datapath is one 33-bit subtractor plus shift registers.
REQ-032 div_iter SHALL be a drop-in port-compatible replacement for the execute stage's signed and unsigned divider instances.

Verification
REQ-033 Scenario: SIGNED=1, dividend 7, divisor 2 -> one tvalid pulse 33 cycles after handshake, tdata 0x00000003_00000001.
REQ-034 Scenario: SIGNED=1, dividend 0xFFFFFFF9 (-7), divisor 2 -> tdata 0xFFFFFFFD_FFFFFFFF; and dividend 0x80000000, divisor 0xFFFFFFFF -> 0x80000000_00000000.
REQ-035 Scenario: SIGNED=0, dividend 0xFFFFFFFF, divisor 0x10 -> tdata 0x0FFFFFFF_0000000F; divisor 0, dividend 0x1234 -> 0xFFFFFFFF_00001234.
REQ-036 Scenario: hold both tvalid high continuously with changing data -> tready low for cycles k+1..k+33, the second request is accepted only after IDLE returns, and each result matches its captured operands.
REQ-037 Scenario: only dividend_tvalid high for 10 cycles -> no acceptance and no tvalid pulse.
REQ-038 Scenario: assert reset at iteration 15 -> no tvalid pulse, tready=1 the cycle after reset, and a following request 100/7 -> 0x0000000E_00000002.
